vga_timing_gen: RTL

Parametrised, runtime-reconfigurable successor to the fixed-mode VGA sync generator. It produces hsync, vsync, data-enable and pixel coordinates for any mode that fits the counter widths. A pixel clock-enable allows slower pixel rates from a fast clk. New timings are loaded over a valid/ready port and applied only at a frame boundary, so no torn frames are produced.

---
 rtl/vga_timing_pkg.sv | 43 ++++
 rtl/vga_axis_counter.sv | 58 +++++
 rtl/vga_timing_gen.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared widths, default 1024x768 timing, timing record types and the legality check.
package vga_timing_pkg;

    localparam int AXIS_W = 16;
    localparam int SUM_W  = AXIS_W + 2;

    localparam int H_W_DEF       = 12;
    localparam int V_W_DEF       = 11;
    localparam int H_DISPLAY_DEF = 1024;
    localparam int H_FRONT_DEF   = 48;
    localparam int H_SYNC_DEF    = 32;
    localparam int H_BACK_DEF    = 80;
    localparam int V_DISPLAY_DEF = 768;
    localparam int V_FRONT_DEF   = 3;
    localparam int V_SYNC_DEF    = 4;
    localparam int V_BACK_DEF    = 15;

    typedef struct packed {
        logic [AXIS_W-1:0] display;
        logic [AXIS_W-1:0] front;
        logic [AXIS_W-1:0] sync;
        logic [AXIS_W-1:0] back;
    } vga_axis_t;

    typedef struct packed {
        vga_axis_t h;
        vga_axis_t v;
    } vga_timing_t;

    function automatic logic [SUM_W-1:0] axis_total(input vga_axis_t a);
        return SUM_W'(a.display) + SUM_W'(a.front) + SUM_W'(a.sync) + SUM_W'(a.back);
    endfunction

    // Each axis total must fit its counter width; display and sync must be non-empty.
    function automatic logic timing_legal(input vga_timing_t t, input int h_w, input int v_w);
        logic h_ok;
        logic v_ok;
        h_ok = (t.h.display != '0) && (t.h.sync != '0) && (axis_total(t.h) < (SUM_W'(1) << h_w));
        v_ok = (t.v.display != '0) && (t.v.sync != '0) && (axis_total(t.v) < (SUM_W'(1) << v_w));
        return h_ok && v_ok;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: position counter with wrap flag and registered display/sync decode.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int         W        = 12,
    parameter bit         SYNC_POL = 1'b1,
    parameter logic [W-1:0] RST_POS = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         adv,
    input  vga_axis_t    axis,
    output logic         at_end,
    output logic [W-1:0] pos,
    output logic         disp_nxt,
    output logic         sync
);

    logic [SUM_W-1:0] total;
    logic [SUM_W-1:0] nxt_ext;
    logic [SUM_W-1:0] sync_lo;
    logic [SUM_W-1:0] sync_hi;
    logic [W-1:0]     pos_nxt;
    logic             disp_q;
    logic             sync_act;
    logic             sync_nxt;

    // Position 0 decodes the same under any legal timing (display, never sync),
    // so a timing swap at the wrap needs no look-ahead into the new fields.
    always_comb begin
        total    = axis_total(axis);
        at_end   = (SUM_W'(pos) + SUM_W'(1)) == total;
        pos_nxt  = at_end ? '0 : pos + 1'b1;
        nxt_ext  = SUM_W'(pos_nxt);
        sync_lo  = SUM_W'(axis.display) + SUM_W'(axis.front);
        sync_hi  = sync_lo + SUM_W'(axis.sync);
        sync_nxt = !at_end && (nxt_ext >= sync_lo) && (nxt_ext < sync_hi);
        disp_nxt = disp_q;
        if (adv) begin
            disp_nxt = at_end || (nxt_ext < SUM_W'(axis.display));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pos      <= RST_POS;
            disp_q   <= 1'b0;
            sync_act <= 1'b0;
        end else if (adv) begin
            pos      <= pos_nxt;
            disp_q   <= disp_nxt;
            sync_act <= sync_nxt;
        end
    end

    assign sync = sync_act ^ ~SYNC_POL;

endmodule

// File: rtl/vga_timing_gen.sv
// Runtime-reconfigurable VGA timing generator; new timings apply only at the frame wrap.
// Optional: define VGA_TIMING_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_W       = H_W_DEF,
    parameter int V_W       = V_W_DEF,
    parameter int H_DISPLAY = H_DISPLAY_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_DISPLAY = V_DISPLAY_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF,
    parameter bit HSYNC_POL = 1'b1,
    parameter bit VSYNC_POL = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           pix_ce,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [H_W-1:0] cfg_h_display,
    input  logic [H_W-1:0] cfg_h_front,
    input  logic [H_W-1:0] cfg_h_sync,
    input  logic [H_W-1:0] cfg_h_back,
    input  logic [V_W-1:0] cfg_v_display,
    input  logic [V_W-1:0] cfg_v_front,
    input  logic [V_W-1:0] cfg_v_sync,
    input  logic [V_W-1:0] cfg_v_back,
    output logic           cfg_error,
    output logic           hsync,
    output logic           vsync,
    output logic           de,
    output logic [H_W-1:0] hpos,
    output logic [V_W-1:0] vpos,
    output logic           line_start,
    output logic           frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0]    frame_cnt
`endif
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam vga_timing_t DEF_TIMING = '{
        h: '{display: AXIS_W'(H_DISPLAY), front: AXIS_W'(H_FRONT),
             sync: AXIS_W'(H_SYNC), back: AXIS_W'(H_BACK)},
        v: '{display: AXIS_W'(V_DISPLAY), front: AXIS_W'(V_FRONT),
             sync: AXIS_W'(V_SYNC), back: AXIS_W'(V_BACK)}
    };

    vga_timing_t active;
    vga_timing_t shadow;
    vga_timing_t cfg_in;
    logic        pending;
    logic        transfer;
    logic        cfg_legal;
    logic        h_end;
    logic        v_end;
    logic        frame_wrap;
    logic        apply;
    logic        h_disp_nxt;
    logic        v_disp_nxt;

    always_comb begin
        cfg_in.h.display = AXIS_W'(cfg_h_display);
        cfg_in.h.front   = AXIS_W'(cfg_h_front);
        cfg_in.h.sync    = AXIS_W'(cfg_h_sync);
        cfg_in.h.back    = AXIS_W'(cfg_h_back);
        cfg_in.v.display = AXIS_W'(cfg_v_display);
        cfg_in.v.front   = AXIS_W'(cfg_v_front);
        cfg_in.v.sync    = AXIS_W'(cfg_v_sync);
        cfg_in.v.back    = AXIS_W'(cfg_v_back);
    end

    assign cfg_legal  = timing_legal(cfg_in, H_W, V_W);
    assign cfg_ready  = !pending;
    assign transfer   = cfg_valid && !pending;
    assign frame_wrap = pix_ce && h_end && v_end;
    assign apply      = frame_wrap && pending;

    always_ff @(posedge clk) begin
        if (!reset) begin
            active    <= DEF_TIMING;
            pending   <= 1'b0;
            cfg_error <= 1'b0;
        end else begin
            cfg_error <= transfer && !cfg_legal;
            if (apply) begin
                active <= shadow;
            end
            if (transfer && cfg_legal) begin
                pending <= 1'b1;
            end else if (apply) begin
                pending <= 1'b0;
            end
        end
    end

    // Shadow contents are only meaningful while pending is set.
    always_ff @(posedge clk) begin
        if (transfer) begin
            shadow <= cfg_in;
        end
    end

    vga_axis_counter #(
        .W        (H_W),
        .SYNC_POL (HSYNC_POL),
        .RST_POS  (H_W'(H_TOTAL - 1))
    ) u_h_axis (
        .clk      (clk),
        .reset    (reset),
        .adv      (pix_ce),
        .axis     (active.h),
        .at_end   (h_end),
        .pos      (hpos),
        .disp_nxt (h_disp_nxt),
        .sync     (hsync)
    );

    vga_axis_counter #(
        .W        (V_W),
        .SYNC_POL (VSYNC_POL),
        .RST_POS  (V_W'(V_TOTAL - 1))
    ) u_v_axis (
        .clk      (clk),
        .reset    (reset),
        .adv      (pix_ce && h_end),
        .axis     (active.v),
        .at_end   (v_end),
        .pos      (vpos),
        .disp_nxt (v_disp_nxt),
        .sync     (vsync)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            de          <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= pix_ce && h_end;
            frame_start <= frame_wrap;
            if (pix_ce) begin
                de <= h_disp_nxt && v_disp_nxt;
            end
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            frame_cnt <= '0;
        end else if (frame_wrap) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule
